// File: rtl/riscv_system_switch_debouncer.sv
// Slide-switch conditioner placed in front of the switch PIO in_port.
// Each bit goes through its own synchroniser chain and debounce FSM.
// A new level is accepted only after it has been seen on DEBOUNCE_CYCLES
// consecutive edges. The accepting edge raises a one-cycle change strobe.

module riscv_system_switch_debouncer_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable,
    output logic changed
);
    typedef enum logic {IDLE, PENDING} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] chain;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;
    state_t                 state;

    assign sync = chain[SYNC_STAGES-1];

    // Plain shift chain: no logic between stages, so the metastability
    // settling time is not reduced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) chain <= '0;
        else          chain <= {chain[SYNC_STAGES-2:0], raw};
    end

    // The counter holds the number of consecutive mismatching edges seen so far.
    // The edge that finds the mismatch for the DEBOUNCE_CYCLES-th time accepts the new level.
    // With a one-cycle window, the first mismatching edge accepts the new level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            stable  <= 1'b0;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (sync != stable) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            stable  <= sync;
                            changed <= 1'b1;
                        end else begin
                            cnt   <= CNT_W'(1);
                            state <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (sync == stable) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        stable  <= sync;
                        changed <= 1'b1;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

module riscv_system_switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_changed
);
    // One independent lane per switch bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        riscv_system_switch_debouncer_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (sw_raw[i]),
            .stable  (sw_stable[i]),
            .changed (sw_changed[i])
        );
    end
endmodule
